ex_div_unit: RTL

Iterative 32-bit divide/remainder responder for the RV32M DIV, DIVU, REM and REMU operations that the execute stage does not compute combinationally.
- The execute stage is the initiator: it issues one request with both resolved (forwarded) operands and stalls until the response returns.
- The unit computes one quotient bit per cycle using restoring division on magnitudes, then applies a sign-fix cycle.

---
 rtl/ex_div_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative RV32M divide/remainder unit.
// Restoring division on operand magnitudes, one quotient bit per cycle,
// followed by a single sign-fix cycle. Divide-by-zero and signed overflow
// are resolved at acceptance and answered on the next cycle.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_opa,
  input  logic [WIDTH-1:0] req_opb,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Magnitude of a value; only signed operands are ever negated.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (sgn && sv < 0) ? -v : v;
  endfunction

  // Conditional two's-complement negation used by the sign-fix cycle.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] div_mag;
  logic             op_rem;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             is_signed;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   shifted;
  logic             trial_ok;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] fix_res;

  assign req_rdy = (state == S_IDLE) && !rst && !flush;
  assign busy    = (state != S_IDLE);
  assign accept  = req_vld && req_rdy;

  // Request decode: operation class and the two answers that bypass iteration.
  always_comb begin
    is_signed   = ~req_op[0];
    b_zero      = (req_opb == '0);
    ovf         = is_signed && (req_opa == MIN_NEG) && (req_opb == '1);
    special_res = '0;
    if (b_zero)
      special_res = req_op[1] ? req_opa : '1;
    else
      special_res = req_op[1] ? '0 : MIN_NEG;
  end

  // One restoring step: shift {rem, quo} left and try to subtract the divisor.
  // The shifted partial remainder needs WIDTH+1 bits; when the subtract
  // succeeds the difference is below the divisor, so WIDTH bits hold it.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial_ok = (shifted >= {1'b0, div_mag});
    trial    = shifted[WIDTH-1:0] - div_mag;
    fix_res  = op_rem ? neg_if(rem, r_neg) : neg_if(quo, q_neg);
  end

  // Control FSM, iteration registers and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
    end else if (flush) begin
      state   <= S_IDLE;
      rsp_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (b_zero || ovf) begin
              rsp_data <= special_res;
              rsp_vld  <= 1'b1;
              state    <= S_DONE;
            end else begin
              quo   <= mag(req_opa, is_signed);
              rem   <= '0;
              cnt   <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo <= {quo[WIDTH-2:0], trial_ok};
          rem <= trial_ok ? trial : shifted[WIDTH-1:0];
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1))
            state <= S_FIX;
        end
        S_FIX: begin
          rsp_data <= fix_res;
          rsp_vld  <= 1'b1;
          state    <= S_DONE;
        end
        default: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Operand attributes captured once at acceptance; held for the whole operation.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_rem  <= req_op[1];
      div_mag <= mag(req_opb, is_signed);
      q_neg   <= is_signed && (req_opa[WIDTH-1] ^ req_opb[WIDTH-1]) && !b_zero;
      r_neg   <= is_signed && req_opa[WIDTH-1];
    end
  end

endmodule
